// File: rtl/tiny_riscv_uart_rx.sv
// tiny_riscv_uart_rx: memory-mapped UART receiver for the tiny RISC-V SoC.
// The serial line is oversampled and deserialised LSB-first. Each frame is
// sampled mid-bit from a half-bit offset taken after the start edge.
// Received bytes go into a first-word-fall-through FIFO. Sticky error flags
// are cleared by i_clear_err.
// Optional feature macro: UART_RX_PARITY_EN. When defined, frames are 8E1 and
// a PARITY state checks even parity. When undefined, frames are 8N1 and
// o_parity_err is constant 0.
module tiny_riscv_uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_UART_RX,
  input  logic       i_pop,
  input  logic       i_clear_err,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_full,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  logic              rx_meta;
  logic              rx_s;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [7:0]        shift;
  logic              brk;
  logic              bit_done;
  logic              push;
  logic              frame_set;
  logic              parity_set;
  logic              overrun_set;
  logic              do_pop;
  logic              do_push;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FCNT_W-1:0] count;

`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_UART_RX;
      rx_s    <= rx_meta;
    end
  end

  // Frame-level events decoded from the current state and the sample point
  always_comb begin
    bit_done   = (cnt == BIT_LAST);
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    if (state == ST_STOP && !brk && bit_done) begin
      if (rx_s) begin
`ifdef UART_RX_PARITY_EN
        push = !par_bad;
`else
        push = 1'b1;
`endif
      end else begin
        frame_set = 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
    if (state == ST_PARITY && bit_done && ((^shift) ^ rx_s)) begin
      parity_set = 1'b1;
    end
`endif
  end

  // Receive FSM: half-bit start check, eight data bits, optional parity, stop
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          brk <= 1'b0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              idx   <= '0;
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_bad <= parity_set;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (brk) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end
          end else if (bit_done) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              brk <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO handshake: pops on empty are ignored, a push into a full FIFO only
  // succeeds if a pop frees the slot in the same cycle
  always_comb begin
    do_pop      = i_pop && (count != '0);
    do_push     = push && ((count != FIFO_FULL) || do_pop);
    overrun_set = push && (count == FIFO_FULL) && !do_pop;
  end

  // FIFO storage; no reset needed because the output is masked when empty
  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      o_overrun    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        o_overrun <= 1'b1;
      end else if (i_clear_err) begin
        o_overrun <= 1'b0;
      end
      if (frame_set) begin
        o_frame_err <= 1'b1;
      end else if (i_clear_err) begin
        o_frame_err <= 1'b0;
      end
      if (parity_set) begin
        o_parity_err <= 1'b1;
      end else if (i_clear_err) begin
        o_parity_err <= 1'b0;
      end
    end
  end

  assign o_rx_valid = (count != '0);
  assign o_rx_full  = (count == FIFO_FULL);
  assign o_rx_data  = o_rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_tiny_riscv_uart_rx.sv
// tb_tiny_riscv_uart_rx: directed and randomised frames checked against a
// queue-based model of the receive FIFO and sticky flags.
module tb_tiny_riscv_uart_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + HALF + 10 * CPB;
`else
  localparam int LAT = 3 + HALF + 9 * CPB;
`endif
  localparam int POP_AT = LAT - 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       pop;
  logic       clear_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       m_ovr;
  logic       m_ferr;
  logic       m_perr;

  tiny_riscv_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_N     (rst_n),
    .i_UART_RX   (rx),
    .i_pop       (pop),
    .i_clear_err (clear_err),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_rx_full   (rx_full),
    .o_overrun   (overrun),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    checkOutput({tag, ".valid"}, {7'd0, rx_valid}, {7'd0, q.size() != 0});
    checkOutput({tag, ".full"}, {7'd0, rx_full}, {7'd0, q.size() == DEPTH});
    checkOutput({tag, ".data"}, rx_data, head);
    checkOutput({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
    checkOutput({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, m_ferr});
    checkOutput({tag, ".parity_err"}, {7'd0, parity_err}, {7'd0, m_perr});
  endtask

  // Drives one frame starting at a negedge; optionally pulses pop on cycle pop_at
  task automatic applyStimulus(input logic [7:0] data, input logic stop_level,
                               input logic par_flip, input int pop_at, output int lat);
    logic fr[11];
    int   nb;
    int   cyc;
    logic par_bad;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1 + i] = data[i];
`ifdef UART_RX_PARITY_EN
    fr[9]   = (^data) ^ par_flip;
    fr[10]  = stop_level;
    nb      = 11;
    par_bad = par_flip;
`else
    fr[9]   = stop_level;
    fr[10]  = 1'b1;
    nb      = 10;
    par_bad = 1'b0;
`endif
    lat = -1;
    cyc = 0;
    for (int b = 0; b < nb; b++) begin
      rx = fr[b];
      for (int k = 0; k < CPB; k++) begin
        pop = (cyc == pop_at);
        @(negedge clk);
        cyc++;
        if (lat < 0 && rx_valid) lat = cyc;
      end
    end
    pop = 1'b0;
    if (pop_at >= 0 && q.size() != 0) void'(q.pop_front());
    if (!stop_level) m_ferr = 1'b1;
    if (par_bad) m_perr = 1'b1;
    if (stop_level && !par_bad) begin
      if (q.size() < DEPTH) q.push_back(data);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic popByte(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    checkOutput({tag, ".head"}, rx_data, head);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clearErr();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Directed scenarios followed by randomised traffic
  initial begin
    int lat;
    int dummy;
    logic [7:0] b;
    logic       stop;
    rst_n = 1'b0; rx = 1'b1; pop = 1'b0; clear_err = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("reset");

    applyStimulus(8'h59, 1'b1, 1'b0, -1, lat);
    checks++;
    assert (((lat >= LAT - 1) && (lat <= LAT + 1)) === 1'b1) else begin
      errors++;
      $error("[TB] FAIL latency observed=%0d expected=%0d+-1", lat, LAT);
    end
    checkAll("byte59");
    popByte("pop59");
    checkAll("empty59");

    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(3 * CPB);
    checkAll("glitch");

    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b0, -1, dummy);
    checkAll("overfill");
    for (int i = 0; i < 4; i++) popByte("drain");
    checkAll("drained");
    popByte("pop_empty");
    checkAll("pop_empty_state");
    clearErr();
    checkAll("clear_ovr");

    applyStimulus(8'hA5, 1'b0, 1'b0, -1, dummy);
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    idle(2 * CPB);
    applyStimulus(8'h3C, 1'b1, 1'b0, -1, dummy);
    checkAll("break");
    popByte("pop3C");
    checkAll("break_empty");
    clearErr();
    checkAll("clear_ferr");

    for (int i = 0; i < DEPTH; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, dummy);
    checkAll("full_again");
    applyStimulus(8'h77, 1'b1, 1'b0, POP_AT, dummy);
    checkAll("push_pop_full");
    for (int i = 0; i < DEPTH; i++) popByte("drain77");
    checkAll("drained77");

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h03, 1'b1, 1'b0, -1, dummy);
    checkAll("par_ok");
    applyStimulus(8'h03, 1'b1, 1'b1, -1, dummy);
    checkAll("par_bad");
    popByte("par_pop");
    clearErr();
    checkAll("par_clear");
`endif

    for (int it = 0; it < 12; it++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      applyStimulus(b, stop, 1'b0, -1, dummy);
      if (!stop) idle(2 * CPB);
      else idle($urandom_range(0, CPB));
      checkAll("rand_rx");
      if ($urandom_range(0, 1) == 1) popByte("rand_pop");
      if ($urandom_range(0, 3) == 0) clearErr();
      checkAll("rand_post");
    end

    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    idle(12 * CPB);
    checkAll("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
